// File: rtl/mc6809_bus_pkg.sv
// ----------------------------------------------------------------------------
// Module  : mc6809_bus_pkg
// Brief   : State encoding, counter widths and window decode for mc6809_bus_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mc6809_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  localparam int unsigned c_hold_w  = 4;
  localparam int unsigned c_stall_w = 8;
  localparam logic [c_hold_w-1:0] c_default_hold = 4'd2;

  // 17-bit compare so a window touching 16'hFFFF cannot wrap around to zero
  function automatic logic win_hit(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] size);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// Module  : sync_edge_det
// Brief   : Two-flop synchronizer with one-cycle rise/fall pulses
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/mc6809_bus_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : mc6809_bus_ctrl
// Brief   : 6809 bus-cycle sequencer: decode, buffer OE/DIR, write strobe, hold.
//           Optional stall timeout enabled by MC6809_BUS_CTRL_TIMEOUT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc6809_bus_ctrl
  import mc6809_bus_pkg::*;
#(
  parameter logic [15:0]          BASE_ADDR      = 16'hE000,
  parameter logic [15:0]          WIN_SIZE       = 16'h1000,
  parameter logic [c_hold_w-1:0]  HOLD_CYCLES    = c_default_hold,
  parameter logic [c_stall_w-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_e_clk,
  input  logic        i_q_clk,
  input  logic        i_rw,
  input  logic        i_ba,
  input  logic [15:0] i_addr,
  output logic        o_buf_oe_n,
  output logic        o_buf_dir,
  output logic        o_cs_n,
  output logic        o_wr_stb,
  output logic [15:0] o_addr,
  output logic        o_rw,
  output logic        o_timeout
);

  logic w_e_rise;
  logic w_e_fall;
  logic w_q_rise;
  logic w_unused_q_fall;
  logic w_q_start;
  logic w_hit;

  bus_state_t            r_state;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic                  r_pend;

  sync_edge_det u_e_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_e_clk),
    .o_rise  (w_e_rise),
    .o_fall  (w_e_fall)
  );

  sync_edge_det u_q_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_q_clk),
    .o_rise  (w_q_rise),
    .o_fall  (w_unused_q_fall)
  );

  // An E fall coinciding with a Q rise wins; the Q rise is dropped
  assign w_q_start = w_q_rise & ~w_e_fall & ~i_ba;
  assign w_hit     = win_hit(i_addr, BASE_ADDR, WIN_SIZE);

`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
  logic [c_stall_w-1:0] r_stall;
  logic                 w_stall_hit;
  assign w_stall_hit = ((r_state == ADDR) || (r_state == ACTIVE)) &&
                       (r_stall == TIMEOUT_CYCLES);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign o_timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_pend     <= 1'b0;
      o_buf_oe_n <= 1'b1;
      o_cs_n     <= 1'b1;
      o_buf_dir  <= 1'b0;
      o_wr_stb   <= 1'b0;
      o_addr     <= 16'h0000;
      o_rw       <= 1'b1;
`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
      r_stall    <= '0;
      o_timeout  <= 1'b0;
`endif
    end else begin
      o_wr_stb <= 1'b0;
`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
      o_timeout <= 1'b0;
      r_stall   <= ((r_state == ADDR) || (r_state == ACTIVE)) ? r_stall + 1'b1 : '0;
`endif
      if (i_ba) begin
        r_state    <= IDLE;
        r_pend     <= 1'b0;
        o_buf_oe_n <= 1'b1;
        o_cs_n     <= 1'b1;
      end
`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
      else if (w_stall_hit) begin
        r_state    <= IDLE;
        r_pend     <= 1'b0;
        o_buf_oe_n <= 1'b1;
        o_cs_n     <= 1'b1;
        o_timeout  <= 1'b1;
      end
`endif
      else begin
        case (r_state)
          IDLE: begin
            if (r_pend) begin
              // Second half of a Q rise taken in HOLD: buffer was off one cycle
              r_pend    <= 1'b0;
              r_state   <= ADDR;
              o_cs_n    <= 1'b0;
              o_buf_dir <= o_rw;
            end else if (w_q_start) begin
              o_addr <= i_addr;
              o_rw   <= i_rw;
              if (w_hit) begin
                r_state   <= ADDR;
                o_cs_n    <= 1'b0;
                o_buf_dir <= i_rw;
              end
            end
          end
          ADDR: begin
            if (w_e_fall) begin
              r_state    <= IDLE;
              o_buf_oe_n <= 1'b1;
              o_cs_n     <= 1'b1;
            end else if (w_e_rise) begin
              r_state    <= ACTIVE;
              o_buf_oe_n <= 1'b0;
`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
              r_stall    <= '0;
`endif
            end
          end
          ACTIVE: begin
            if (w_e_fall) begin
              r_state    <= HOLD;
              r_hold_cnt <= HOLD_CYCLES;
              o_wr_stb   <= ~o_rw;
            end
          end
          HOLD: begin
            if (w_q_start) begin
              r_state    <= IDLE;
              r_pend     <= w_hit;
              o_buf_oe_n <= 1'b1;
              o_cs_n     <= 1'b1;
              o_addr     <= i_addr;
              o_rw       <= i_rw;
            end else if (r_hold_cnt == '0) begin
              r_state    <= IDLE;
              o_buf_oe_n <= 1'b1;
              o_cs_n     <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc6809_bus_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : tb_mc6809_bus_ctrl
// Brief   : Self-checking bench; four instances differing in hold/timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mc6809_bus_ctrl;

  localparam int P = 25;  // fast-clock cycles per E/Q quarter period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_clk = 1'b0;
  logic        q_clk = 1'b0;
  logic        rw_in = 1'b1;
  logic        ba = 1'b0;
  logic [15:0] addr_in = 16'h0000;

  logic [3:0]  oe_n, dir, cs_n, wr, rw_o, to;
  logic [15:0] addr_o [4];

  int c_hold [4] = '{2, 0, 15, 2};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mc6809_bus_ctrl #(
      .BASE_ADDR      (16'hE000),
      .WIN_SIZE       (16'h1000),
      .HOLD_CYCLES    ((g == 1) ? 4'd0 : (g == 2) ? 4'd15 : 4'd2),
      .TIMEOUT_CYCLES ((g == 3) ? 8'd20 : 8'd255)
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_e_clk    (e_clk),
      .i_q_clk    (q_clk),
      .i_rw       (rw_in),
      .i_ba       (ba),
      .i_addr     (addr_in),
      .o_buf_oe_n (oe_n[g]),
      .o_buf_dir  (dir[g]),
      .o_cs_n     (cs_n[g]),
      .o_wr_stb   (wr[g]),
      .o_addr     (addr_o[g]),
      .o_rw       (rw_o[g]),
      .o_timeout  (to[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          inst;
    logic        oe_n;
    logic        cs_n;
    logic        dir;
    logic        wr;
    logic [15:0] addr;
    logic        rw;
    string       tag;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic        hit;
    string       tag;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs [6];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] m_addr = 16'h0000;
  logic        m_rw = 1'b1;
  logic        m_dir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input int k, input logic e_oe, input logic e_cs,
                           input logic e_dir, input logic e_wr, input string tag);
    exp_t e;
    e.cyc = c; e.inst = k; e.oe_n = e_oe; e.cs_n = e_cs; e.dir = e_dir; e.wr = e_wr;
    e.addr = m_addr; e.rw = m_rw; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic r, input logic h, input string t);
    vec_t v;
    v.addr = a; v.rw = r; v.hit = h; v.tag = t;
    return v;
  endfunction

  // Scoreboard drain and bus-direction watch, sampled 1 ns after each rising edge
  initial begin
    logic [3:0] prev_oe;
    logic [3:0] prev_dir;
    prev_oe = 4'hF;
    prev_dir = 4'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          int k;
          k = sb[i].inst;
          checks++;
          if (oe_n[k] !== sb[i].oe_n || cs_n[k] !== sb[i].cs_n || dir[k] !== sb[i].dir ||
              wr[k] !== sb[i].wr || addr_o[k] !== sb[i].addr || rw_o[k] !== sb[i].rw) begin
            failures++;
            $display("FAIL %s inst%0d cyc%0d: got oe_n=%b cs_n=%b dir=%b wr=%b addr=%h rw=%b required oe_n=%b cs_n=%b dir=%b wr=%b addr=%h rw=%b",
                     sb[i].tag, k, cyc, oe_n[k], cs_n[k], dir[k], wr[k], addr_o[k], rw_o[k],
                     sb[i].oe_n, sb[i].cs_n, sb[i].dir, sb[i].wr, sb[i].addr, sb[i].rw);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s inst%0d: check at cyc%0d was never reached", sb[i].tag, sb[i].inst, sb[i].cyc);
          sb.delete(i);
        end
      end
      if (rst_n) begin
        for (int k = 0; k < 4; k++) begin
          if (prev_oe[k] == 1'b0 && oe_n[k] == 1'b0) begin
            checks++;
            if (dir[k] !== prev_dir[k]) begin
              failures++;
              $display("FAIL dir_under_oe inst%0d cyc%0d: got dir=%b required dir=%b", k, cyc, dir[k], prev_dir[k]);
            end
          end
        end
      end
      prev_oe = oe_n;
      prev_dir = dir;
    end
  end

  // One full E/Q cycle; b2b marks a Q rise landing inside the HOLD of instance 2
  task automatic run_cycle(input logic [15:0] a, input logic r, input logic hit,
                           input int tail, input logic b2b, input string tag);
    int   n, m, f, h;
    logic old_dir;
    old_dir = m_dir;
    @(negedge clk);
    addr_in = a; rw_in = r; q_clk = 1'b1; n = cyc + 1;
    m_addr = a; m_rw = r;
    if (hit) m_dir = r;
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && b2b) begin
        expect_at(n + 2, k, 1'b1, 1'b1, old_dir, 1'b0, {tag, ":b2b_gap"});
        expect_at(n + 3, k, 1'b1, !hit, m_dir, 1'b0, {tag, ":b2b_addr"});
      end else begin
        expect_at(n + 2, k, 1'b1, !hit, m_dir, 1'b0, {tag, ":q_rise"});
      end
    end
    wait_cyc(P - 1);
    @(negedge clk);
    e_clk = 1'b1; m = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      expect_at(m + 1, k, 1'b1, !hit, m_dir, 1'b0, {tag, ":pre_oe"});
      expect_at(m + 2, k, !hit, !hit, m_dir, 1'b0, {tag, ":e_rise"});
    end
    wait_cyc(P - 1);
    @(negedge clk);
    q_clk = 1'b0;
    wait_cyc(P - 1);
    @(negedge clk);
    e_clk = 1'b0; f = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      h = c_hold[k];
      if (!hit) begin
        expect_at(f + 2, k, 1'b1, 1'b1, m_dir, 1'b0, {tag, ":e_fall_idle"});
      end else begin
        expect_at(f + 2, k, 1'b0, 1'b0, m_dir, !r, {tag, ":hold_entry"});
        if (h == 0) begin
          expect_at(f + 3, k, 1'b1, 1'b1, m_dir, 1'b0, {tag, ":hold0_off"});
        end else begin
          expect_at(f + 3, k, 1'b0, 1'b0, m_dir, 1'b0, {tag, ":stb_end"});
          if (k != 2 || tail >= 17) begin
            expect_at(f + 2 + h, k, 1'b0, 1'b0, m_dir, 1'b0, {tag, ":hold_last"});
            expect_at(f + 3 + h, k, 1'b1, 1'b1, m_dir, 1'b0, {tag, ":hold_off"});
          end
        end
      end
    end
    wait_cyc(tail - 1);
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_oe_n"}, 32'(oe_n[k]), 32'd1);
      chk({tag, "_cs_n"}, 32'(cs_n[k]), 32'd1);
      chk({tag, "_dir"},  32'(dir[k]),  32'd0);
      chk({tag, "_wr"},   32'(wr[k]),   32'd0);
      chk({tag, "_to"},   32'(to[k]),   32'd0);
      chk({tag, "_addr"}, 32'(addr_o[k]), 32'd0);
      chk({tag, "_rw"},   32'(rw_o[k]), 32'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, f, b, tcnt;
    vecs[0] = mk(16'hE010, 1'b1, 1'b1, "read_e010");
    vecs[1] = mk(16'hEFFF, 1'b0, 1'b1, "write_efff");
    vecs[2] = mk(16'hF000, 1'b1, 1'b0, "miss_f000");
    vecs[3] = mk(16'hDFFF, 1'b0, 1'b0, "miss_dfff");
    vecs[4] = mk(16'hE000, 1'b1, 1'b1, "read_e000");
    vecs[5] = mk(16'hE800, 1'b0, 1'b1, "write_e800");

    wait_cyc(3);
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(4);

    for (int i = 0; i < 6; i++)
      run_cycle(vecs[i].addr, vecs[i].rw, vecs[i].hit, P, 1'b0, vecs[i].tag);

    // Back-to-back: short E period so the next Q rise lands in the 15-cycle hold
    run_cycle(16'hE010, 1'b1, 1'b1, 5, 1'b0, "b2b_first");
    run_cycle(16'hE020, 1'b0, 1'b1, P, 1'b1, "b2b_second");

    // E rise coincides with Q rise and is ignored, so E fall arrives in ADDR
    @(negedge clk);
    addr_in = 16'hE040; rw_in = 1'b0; q_clk = 1'b1; e_clk = 1'b1; n = cyc + 1;
    m_addr = 16'hE040; m_rw = 1'b0; m_dir = 1'b0;
    for (int k = 0; k < 3; k++) expect_at(n + 2, k, 1'b1, 1'b0, 1'b0, 1'b0, "missed_erise:addr");
    wait_cyc(P - 1);
    @(negedge clk); q_clk = 1'b0;
    wait_cyc(P - 1);
    @(negedge clk); e_clk = 1'b0; f = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      expect_at(f + 2, k, 1'b1, 1'b1, 1'b0, 1'b0, "missed_erise:abort");
      expect_at(f + 3, k, 1'b1, 1'b1, 1'b0, 1'b0, "missed_erise:no_stb");
    end
    wait_cyc(P - 1);

    // Bus release while ACTIVE on a write
    @(negedge clk);
    addr_in = 16'hE030; rw_in = 1'b0; q_clk = 1'b1; n = cyc + 1;
    m_addr = 16'hE030; m_rw = 1'b0; m_dir = 1'b0;
    for (int k = 0; k < 3; k++) expect_at(n + 2, k, 1'b1, 1'b0, 1'b0, 1'b0, "ba:q_rise");
    wait_cyc(P - 1);
    @(negedge clk); e_clk = 1'b1; m = cyc + 1;
    for (int k = 0; k < 3; k++) expect_at(m + 2, k, 1'b0, 1'b0, 1'b0, 1'b0, "ba:active");
    wait_cyc(P - 1);
    @(negedge clk); q_clk = 1'b0; ba = 1'b1; b = cyc + 1;
    for (int k = 0; k < 3; k++) expect_at(b, k, 1'b1, 1'b1, 1'b0, 1'b0, "ba:release");
    wait_cyc(P - 1);
    @(negedge clk); e_clk = 1'b0; f = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      expect_at(f + 2, k, 1'b1, 1'b1, 1'b0, 1'b0, "ba:e_fall");
      expect_at(f + 3, k, 1'b1, 1'b1, 1'b0, 1'b0, "ba:no_stb");
    end
    wait_cyc(P - 1);
    @(negedge clk); ba = 1'b0;
    wait_cyc(4);

    // Asynchronous reset while ACTIVE
    @(negedge clk);
    addr_in = 16'hE050; rw_in = 1'b1; q_clk = 1'b1; n = cyc + 1;
    m_addr = 16'hE050; m_rw = 1'b1; m_dir = 1'b1;
    for (int k = 0; k < 3; k++) expect_at(n + 2, k, 1'b1, 1'b0, 1'b1, 1'b0, "rst:q_rise");
    wait_cyc(P - 1);
    @(negedge clk); e_clk = 1'b1; m = cyc + 1;
    for (int k = 0; k < 3; k++) expect_at(m + 2, k, 1'b0, 1'b0, 1'b1, 1'b0, "rst:active");
    wait_cyc(P + 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    q_clk = 1'b0; e_clk = 1'b0;
    m_addr = 16'h0000; m_rw = 1'b1; m_dir = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);

    // Stall: E never rises after a hit; instance 3 has the short timeout
    @(negedge clk);
    addr_in = 16'hE060; rw_in = 1'b1; q_clk = 1'b1;
    tcnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (to[3]) tcnt++;
    end
`ifdef MC6809_BUS_CTRL_TIMEOUT_EN
    chk("timeout_pulse_count", 32'(tcnt), 32'd1);
    chk("timeout_cs_n", 32'(cs_n[3]), 32'd1);
    chk("timeout_oe_n", 32'(oe_n[3]), 32'd1);
`else
    chk("no_timeout_pulse_count", 32'(tcnt), 32'd0);
    chk("no_timeout_cs_n", 32'(cs_n[3]), 32'd0);
`endif

    wait_cyc(5);
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s inst%0d: check at cyc%0d left pending", sb[0].tag, sb[0].inst, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
